// File: rtl/spi_slave_receiver.sv
// spi_slave_receiver: parses SD-style SPI command frames (start/tx bits, index, argument, CRC, end bit)
// and consumes the data block that follows a block-write command.
module spi_slave_receiver #(
    parameter logic [5:0] WRITE_CMD_A = 6'd24,
    parameter logic [5:0] WRITE_CMD_B = 6'd25,
    parameter logic [7:0] START_TOKEN = 8'hFE
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  io_InputBuffer,
    input  logic        io_BufferChanged,
    input  logic [31:0] io_DataBlockSize,
    output logic        io_CommandReadFinished,
    output logic        io_ArgumentReadFinished,
    output logic        io_ReadSuccess,
    output logic [5:0]  io_Command,
    output logic [31:0] io_CommandArgument,
    output logic [2:0]  io____state
);
    typedef enum logic [2:0] {IDLE, TXBIT, CMD, ARG, CRC, ENDB, DWAIT, DATA} state_t;
    state_t state, state_n;
    logic [31:0] cnt, cnt_n, size, size_n, arg_n;
    logic [5:0] cmd_n;
    logic cmd_done_n, arg_done_n, ok_n, chg_q, ev, b;
    assign ev = io_BufferChanged & ~chg_q;
    assign b = io_InputBuffer[0];
    assign io____state = state;
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            cnt <= '0;
            size <= '0;
            chg_q <= 1'b0;
            io_Command <= '0;
            io_CommandArgument <= '0;
            io_CommandReadFinished <= 1'b0;
            io_ArgumentReadFinished <= 1'b0;
            io_ReadSuccess <= 1'b0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            size <= size_n;
            chg_q <= io_BufferChanged;
            io_Command <= cmd_n;
            io_CommandArgument <= arg_n;
            io_CommandReadFinished <= cmd_done_n;
            io_ArgumentReadFinished <= arg_done_n;
            io_ReadSuccess <= ok_n;
        end
    end
    always_comb begin
        state_n = state;
        cnt_n = cnt;
        size_n = size;
        cmd_n = io_Command;
        arg_n = io_CommandArgument;
        cmd_done_n = io_CommandReadFinished;
        arg_done_n = io_ArgumentReadFinished;
        ok_n = io_ReadSuccess;
        if (ev) begin
            case (state)
                IDLE: if (!b) begin
                    cmd_done_n = 1'b0;
                    arg_done_n = 1'b0;
                    ok_n = 1'b0;
                    state_n = TXBIT;
                end
                TXBIT: begin
                    state_n = b ? CMD : IDLE;
                    cnt_n = '0;
                end
                CMD: begin
                    cmd_n = {io_Command[4:0], b};
                    cnt_n = cnt + 32'd1;
                    if (cnt == 32'd5) begin
                        cmd_done_n = 1'b1;
                        cnt_n = '0;
                        state_n = ARG;
                    end
                end
                ARG: begin
                    arg_n = {io_CommandArgument[30:0], b};
                    cnt_n = cnt + 32'd1;
                    if (cnt == 32'd31) begin
                        arg_done_n = 1'b1;
                        cnt_n = '0;
                        state_n = CRC;
                    end
                end
                CRC: begin
                    cnt_n = cnt + 32'd1;
                    if (cnt == 32'd6) begin
                        cnt_n = '0;
                        state_n = ENDB;
                    end
                end
                ENDB: begin
                    ok_n = b;
                    state_n = (b && (io_Command == WRITE_CMD_A || io_Command == WRITE_CMD_B)) ? DWAIT : IDLE;
                end
                DWAIT: if (io_InputBuffer == START_TOKEN) begin
                    size_n = io_DataBlockSize;
                    cnt_n = '0;
                    state_n = DATA;
                end
                DATA: begin
                    // payload bytes plus the trailing 16-bit data CRC
                    cnt_n = cnt + 32'd1;
                    if (cnt == {size[28:0], 3'b000} + 32'd15) begin
                        cnt_n = '0;
                        state_n = IDLE;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_slave_receiver.sv
// tb_spi_slave_receiver: randomized frames checked against a frame-layout reference model.
module tb_spi_slave_receiver;
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic [7:0] io_InputBuffer = 8'hFF;
    logic io_BufferChanged = 1'b0;
    logic [31:0] io_DataBlockSize = '0;
    logic io_CommandReadFinished, io_ArgumentReadFinished, io_ReadSuccess;
    logic [5:0] io_Command;
    logic [31:0] io_CommandArgument;
    logic [2:0] io____state;
    logic [7:0] win = 8'hFF;
    int total = 0;
    int bad = 0;

    spi_slave_receiver dut (
        .clock(clock), .reset(reset), .io_InputBuffer(io_InputBuffer),
        .io_BufferChanged(io_BufferChanged), .io_DataBlockSize(io_DataBlockSize),
        .io_CommandReadFinished(io_CommandReadFinished), .io_ArgumentReadFinished(io_ArgumentReadFinished),
        .io_ReadSuccess(io_ReadSuccess), .io_Command(io_Command),
        .io_CommandArgument(io_CommandArgument), .io____state(io____state)
    );

    always #5 clock = ~clock;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_flags(input string tag, input logic c, input logic a, input logic s);
        check({tag, ".cmd_done"}, 32'(io_CommandReadFinished), 32'(c));
        check({tag, ".arg_done"}, 32'(io_ArgumentReadFinished), 32'(a));
        check({tag, ".success"}, 32'(io_ReadSuccess), 32'(s));
    endtask

    task automatic send_bit(input logic b, input int hold);
        win = {win[6:0], b};
        @(negedge clock);
        io_InputBuffer = win;
        io_BufferChanged = 1'b1;
        repeat (hold - 1) @(negedge clock);
        @(negedge clock);
        io_BufferChanged = 1'b0;
    endtask

    // state after bit p of a 48-bit command frame, derived from the field layout
    function automatic logic [2:0] frame_state(input int p);
        if (p == 0) return 3'd1;
        if (p <= 6) return 3'd2;
        if (p <= 38) return 3'd3;
        if (p <= 45) return 3'd4;
        return 3'd5;
    endfunction

    task automatic send_frame(input logic [5:0] cmd, input logic [31:0] arg, input logic endb, input int hold);
        logic [47:0] f;
        f = {1'b0, 1'b1, cmd, arg, 7'($urandom), endb};
        for (int p = 0; p < 48; p++) begin
            send_bit(f[47 - p], hold);
            if (p < 47) check($sformatf("state@bit%0d", p), 32'(io____state), 32'(frame_state(p)));
            if (p == 7) check("cmd_done@8", 32'(io_CommandReadFinished), 32'd1);
            if (p == 39) check("arg_done@40", 32'(io_ArgumentReadFinished), 32'd1);
        end
        check("command", 32'(io_Command), 32'(cmd));
        check("argument", io_CommandArgument, arg);
        check_flags("frame", 1'b1, 1'b1, endb);
        check("state_after_end", 32'(io____state), (endb && (cmd == 6'd24 || cmd == 6'd25)) ? 32'd6 : 32'd0);
    endtask

    task automatic do_reset;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        logic [5:0] c;
        logic [31:0] a;
        int n;
        do_reset();
        check("reset.state", 32'(io____state), 32'd0);
        check("reset.cmd", 32'(io_Command), 32'd0);
        check("reset.arg", io_CommandArgument, 32'd0);
        check_flags("reset", 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            send_bit(1'b1, 1);
            check("idle.state", 32'(io____state), 32'd0);
        end
        check_flags("idle", 1'b0, 1'b0, 1'b0);

        send_frame(6'd16, 32'h0000_0800, 1'b1, 1);
        send_frame(6'd16, 32'h0000_0800, 1'b1, 2);

        send_bit(1'b0, 1);
        send_bit(1'b0, 1);
        check("txerr.state", 32'(io____state), 32'd0);
        check_flags("txerr", 1'b0, 1'b0, 1'b0);

        send_frame(6'd17, $urandom, 1'b0, 1);

        for (int i = 0; i < 6; i++) begin
            do c = 6'($urandom); while (c == 6'd24 || c == 6'd25);
            send_frame(c, $urandom, 1'($urandom), $urandom_range(1, 3));
        end

        for (int k = 0; k < 3; k++) begin
            io_DataBlockSize = (k == 0) ? 32'd2 : (k == 1) ? 32'd0 : 32'($urandom_range(1, 5));
            n = io_DataBlockSize * 8 + 16;
            send_frame((k == 1) ? 6'd25 : 6'd24, $urandom, 1'b1, 1);
            repeat (3) send_bit(1'b1, 1);
            check("dwait.hold", 32'(io____state), 32'd6);
            for (int i = 7; i >= 0; i--) send_bit(i != 0, $urandom_range(1, 2));
            check("token.state", 32'(io____state), 32'd7);
            io_DataBlockSize = 32'd100;
            for (int i = 0; i < n; i++) begin
                send_bit(1'($urandom), 1);
                check($sformatf("data%0d.bit%0d", k, i), 32'(io____state), (i < n - 1) ? 32'd7 : 32'd0);
            end
        end

        c = 6'($urandom);
        a = $urandom;
        for (int p = 0; p < 20; p++) send_bit((p == 0) ? 1'b0 : (p == 1) ? 1'b1 : 1'($urandom), 1);
        check("pre_reset.state", 32'(io____state), 32'd3);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("midreset.state", 32'(io____state), 32'd0);
        check("midreset.cmd", 32'(io_Command), 32'd0);
        check("midreset.arg", io_CommandArgument, 32'd0);
        check_flags("midreset", 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        send_frame(c, a, 1'b1, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
